// File: rtl/pp_pkg.sv
// Shared types and width helpers for the ping-pong post-processing buffer.
package pp_pkg;

    typedef enum logic [1:0] {
        B_FREE,
        B_FILLING,
        B_READY,
        B_DRAINING
    } bank_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ADDR,
        R_LOAD,
        R_OUT
    } rd_state_t;

    function automatic int addr_w(input int depth_words);
        return (depth_words > 1) ? $clog2(depth_words) : 1;
    endfunction

    function automatic int cnt_w(input int depth_words);
        return $clog2(depth_words + 1);
    endfunction

    function automatic int lane_w(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/post_process_pp_if.sv
// Capture-word write handshake and serial sample stream of the ping-pong buffer.
interface post_process_pp_if #(
    parameter int SAMPLE_W = 16,
    parameter int LANES    = 4
);
    logic                      in_valid;
    logic                      in_ready;
    logic [LANES*SAMPLE_W-1:0] in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [SAMPLE_W-1:0]       out_data;
    logic                      out_last;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/pp_sdp_ram.sv
// Simple dual-port RAM, one write port and one registered read port (1-cycle latency).
module pp_sdp_ram #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    localparam int WORDS = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [WORDS];

    // NOTE: neither the array nor the read register is reset, so this maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end
endmodule

// File: rtl/post_process_pp.sv
// Ping-pong capture buffer: wide words fill two RAM banks alternately while the
// other bank is serialised into single samples for the UART transmitter.
module post_process_pp
    import pp_pkg::*;
#(
    parameter int SAMPLE_W    = 16,
    parameter int LANES       = 4,
    parameter int DEPTH_WORDS = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             begin_pp,
    input  logic             end_pp,
    post_process_pp_if.slave bus,
    output logic             bank_full,
    output logic             bank_empty,
    output logic             ended
);
    localparam int ADDR_W = addr_w(DEPTH_WORDS);
    localparam int CNT_W  = cnt_w(DEPTH_WORDS);
    localparam int LANE_W = lane_w(LANES);
    localparam int DATA_W = LANES * SAMPLE_W;

    bank_state_t        bank_st  [2];
    bank_state_t        bank_nxt [2];
    logic [CNT_W-1:0]   bank_cnt [2];
    logic [CNT_W-1:0]   cnt_nxt  [2];

    logic               wr_bank;
    logic               wr_oth;
    logic [ADDR_W-1:0]  wr_ad;
    logic               flush_seen;

    rd_state_t          rd_state;
    rd_state_t          rd_nxt;
    logic               rd_bank;
    logic               rd_oth;
    logic               next_rd;
    logic [ADDR_W-1:0]  rd_ad;
    logic [LANE_W-1:0]  lane;
    logic [DATA_W-1:0]  shift_q;
    logic [DATA_W-1:0]  ram_rd_data;
    logic               ram_rd_en;

    logic               wr_fire;
    logic               wr_filling;
    logic [CNT_W-1:0]   fill_cnt;
    logic               flush_now;
    logic               seal_full;
    logic               seal_flush;
    logic               seal;
    logic               drop_empty;
    logic               rd_start;
    logic               rd_hs;
    logic               word_end;
    logic               last_word;
    logic               rd_done;
    logic               oth_busy;
    logic               all_free;

    assign wr_oth     = ~wr_bank;
    assign rd_oth     = ~rd_bank;
    assign wr_filling = (bank_st[wr_bank] == B_FILLING);
    assign wr_fire    = bus.in_valid & bus.in_ready;
    assign fill_cnt   = CNT_W'(wr_ad) + CNT_W'(wr_fire);
    assign flush_now  = begin_pp & end_pp & ~flush_seen;
    assign seal_full  = wr_fire & (wr_ad == ADDR_W'(DEPTH_WORDS - 1));
    assign seal_flush = flush_now & wr_filling & ~seal_full & (fill_cnt != '0);
    assign drop_empty = flush_now & wr_filling & (fill_cnt == '0);
    assign seal       = seal_full | seal_flush;

    assign rd_start  = (rd_state == R_IDLE) & (bank_st[next_rd] == B_READY);
    assign rd_hs     = bus.out_valid & bus.out_ready;
    assign word_end  = rd_hs & (lane == LANE_W'(LANES - 1));
    assign last_word = (CNT_W'(rd_ad) == bank_cnt[rd_bank] - CNT_W'(1));
    assign rd_done   = word_end & last_word;
    assign all_free  = (bank_st[0] == B_FREE) & (bank_st[1] == B_FREE);

    // Data still owed by the other bank means this drain cannot carry the final sample.
    assign oth_busy = (bank_st[rd_oth] == B_READY) |
                      ((bank_st[rd_oth] == B_FILLING) & (wr_ad != '0));

    assign bus.in_ready = begin_pp & ~flush_seen & wr_filling;
    assign bus.out_data = bus.out_valid ? shift_q[SAMPLE_W-1:0] : '0;
    assign bus.out_last = bus.out_valid & flush_seen & (lane == LANE_W'(LANES - 1)) &
                          last_word & ~oth_busy;

    // Bank ownership: writer and reader only ever touch banks in disjoint states.
    always_comb begin
        // NOTE: every target gets its default first so no path leaves it unassigned (no latch).
        bank_nxt = bank_st;
        cnt_nxt  = bank_cnt;
        if (bank_st[wr_bank] == B_FREE && !flush_seen && !flush_now) begin
            bank_nxt[wr_bank] = B_FILLING;
        end
        if (seal) begin
            bank_nxt[wr_bank] = B_READY;
            cnt_nxt[wr_bank]  = fill_cnt;
            if (!flush_now && bank_st[wr_oth] == B_FREE) begin
                bank_nxt[wr_oth] = B_FILLING;
            end
        end
        if (drop_empty) begin
            bank_nxt[wr_bank] = B_FREE;
        end
        if (rd_start) begin
            bank_nxt[next_rd] = B_DRAINING;
        end
        if (rd_done) begin
            bank_nxt[rd_bank] = B_FREE;
            cnt_nxt[rd_bank]  = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                bank_st[b]  <= B_FREE;
                bank_cnt[b] <= '0;
            end
            wr_bank    <= 1'b0;
            wr_ad      <= '0;
            flush_seen <= 1'b0;
            bank_full  <= 1'b0;
        end else if (!begin_pp) begin
            for (int b = 0; b < 2; b++) begin
                bank_st[b]  <= B_FREE;
                bank_cnt[b] <= '0;
            end
            wr_bank    <= 1'b0;
            wr_ad      <= '0;
            flush_seen <= 1'b0;
            bank_full  <= 1'b0;
        end else begin
            bank_st   <= bank_nxt;
            bank_cnt  <= cnt_nxt;
            bank_full <= seal;
            if (flush_now) begin
                flush_seen <= 1'b1;
            end
            if (seal) begin
                wr_ad   <= '0;
                wr_bank <= wr_oth;
            end else if (wr_fire) begin
                wr_ad <= wr_ad + ADDR_W'(1);
            end
        end
    end

    pp_sdp_ram #(
        .ADDR_W (ADDR_W + 1),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_fire),
        .wr_addr ({wr_bank, wr_ad}),
        .wr_data (bus.in_data),
        .rd_en   (ram_rd_en),
        .rd_addr ({rd_bank, rd_ad}),
        .rd_data (ram_rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state <= R_IDLE;
        end else begin
            rd_state <= rd_nxt;
        end
    end

    always_comb begin
        rd_nxt = rd_state;
        unique case (rd_state)
            R_IDLE:  if (bank_st[next_rd] == B_READY) rd_nxt = R_ADDR;
            R_ADDR:  rd_nxt = R_LOAD;
            R_LOAD:  rd_nxt = R_OUT;
            R_OUT:   if (word_end) rd_nxt = last_word ? R_IDLE : R_ADDR;
            default: rd_nxt = R_IDLE;
        endcase
        if (!begin_pp) begin
            rd_nxt = R_IDLE;
        end
    end

    always_comb begin
        bus.out_valid = (rd_state == R_OUT);
        ram_rd_en     = (rd_state == R_ADDR);
    end

    // Reader datapath: banks are sealed alternately, so a toggling pointer serves oldest first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_bank    <= 1'b0;
            next_rd    <= 1'b0;
            rd_ad      <= '0;
            lane       <= '0;
            shift_q    <= '0;
            bank_empty <= 1'b0;
            ended      <= 1'b0;
        end else if (!begin_pp) begin
            rd_bank    <= 1'b0;
            next_rd    <= 1'b0;
            rd_ad      <= '0;
            lane       <= '0;
            shift_q    <= '0;
            bank_empty <= 1'b0;
            ended      <= 1'b0;
        end else begin
            bank_empty <= rd_done;
            if (rd_start) begin
                rd_bank <= next_rd;
                next_rd <= ~next_rd;
            end
            if (rd_state == R_LOAD) begin
                shift_q <= ram_rd_data;
                lane    <= '0;
            end else if (rd_hs) begin
                shift_q <= shift_q >> SAMPLE_W;
                lane    <= lane + LANE_W'(1);
            end
            if (word_end) begin
                rd_ad <= rd_done ? '0 : rd_ad + ADDR_W'(1);
            end
            if (rd_hs && bus.out_last) begin
                ended <= 1'b1;
            end else if (flush_seen && all_free && rd_state == R_IDLE) begin
                ended <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_post_process_pp.sv
// Directed bench for post_process_pp: bursts, backpressure, flushes and restarts.
module tb_post_process_pp;
    localparam int SAMPLE_W    = 16;
    localparam int LANES       = 4;
    localparam int DEPTH_WORDS = 32;
    localparam int DATA_W      = SAMPLE_W * LANES;
    localparam int MAX_SMP     = 4096;

    logic clk = 1'b0;
    logic rst_n;
    logic begin_pp;
    logic end_pp;
    logic bank_full;
    logic bank_empty;
    logic ended;

    post_process_pp_if #(.SAMPLE_W(SAMPLE_W), .LANES(LANES)) bus ();

    post_process_pp #(
        .SAMPLE_W    (SAMPLE_W),
        .LANES       (LANES),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .begin_pp   (begin_pp),
        .end_pp     (end_pp),
        .bus        (bus),
        .bank_full  (bank_full),
        .bank_empty (bank_empty),
        .ended      (ended)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    int                  cyc = 0;
    logic [SAMPLE_W-1:0] smp_q  [MAX_SMP];
    logic                last_q [MAX_SMP];
    int                  n_smp = 0;
    int                  n_full = 0;
    int                  n_empty = 0;
    int                  n_last = 0;
    int                  n_stall = 0;
    int                  last_hs_cyc = -1;
    int                  ended_rise_cyc = -1;
    logic                ended_d = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready && n_smp < MAX_SMP) begin
            smp_q[n_smp]  = bus.out_data;
            last_q[n_smp] = bus.out_last;
            n_smp++;
            if (bus.out_last) begin
                n_last++;
                last_hs_cyc = cyc;
            end
        end
        if (bank_full)  n_full++;
        if (bank_empty) n_empty++;
        if (bus.in_valid && !bus.in_ready) n_stall++;
        if (ended && !ended_d) ended_rise_cyc = cyc;
        ended_d = ended;
    end

    int rdy_mode = 0;
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = (rdy_mode == 0) ? 1'b1 : ~bus.out_ready;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic push_word(input logic [DATA_W-1:0] d);
        int t = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        @(negedge clk);
        while (!bus.in_ready && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("push_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // distinct=0: every lane of word k carries base+k; distinct=1: lane j carries base+k*LANES+j.
    task automatic push_burst(input int n, input int base, input bit distinct);
        logic [DATA_W-1:0] w;
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < LANES; j++) begin
                w[j*SAMPLE_W +: SAMPLE_W] = distinct ? SAMPLE_W'(base + k*LANES + j)
                                                     : SAMPLE_W'(base + k);
            end
            push_word(w);
        end
    endtask

    task automatic wait_smp(input int target, input int budget);
        int t = 0;
        while (n_smp < target && t < budget) begin
            @(negedge clk);
            t++;
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic check_stream(input string tag, input int base, input int n_exp,
                                input int first, input bit distinct);
        int bad = 0;
        int exp_v;
        check({tag, "_count"}, n_smp - base, n_exp);
        for (int i = 0; i < n_exp && base + i < n_smp; i++) begin
            exp_v = distinct ? first + i : first + i / LANES;
            if (smp_q[base + i] !== SAMPLE_W'(exp_v)) bad++;
        end
        check({tag, "_data_bad"}, bad, 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_out_valid"},  bus.out_valid, 0);
        check({tag, "_in_ready"},   bus.in_ready, 0);
        check({tag, "_out_data"},   bus.out_data, 0);
        check({tag, "_out_last"},   bus.out_last, 0);
        check({tag, "_bank_full"},  bank_full, 0);
        check({tag, "_bank_empty"}, bank_empty, 0);
        check({tag, "_ended"},      ended, 0);
    endtask

    task automatic restart();
        @(posedge clk);
        #1;
        begin_pp = 1'b0;
        @(posedge clk);
        #1;
        begin_pp = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic pulse_end();
        end_pp = 1'b1;
        @(posedge clk);
        #1;
        end_pp = 1'b0;
    endtask

    int b, f0, e0, l0, s0;

    initial begin
        rst_n        = 1'b0;
        begin_pp     = 1'b0;
        end_pp       = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        begin_pp = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("begin_in_ready", bus.in_ready, 1);

        // One full bank, ready always high.
        b = n_smp; f0 = n_full; e0 = n_empty; l0 = n_last;
        push_burst(32, 0, 1'b0);
        wait_smp(b + 128, 2000);
        check_stream("t1", b, 128, 0, 1'b0);
        check("t1_bank_full", n_full - f0, 1);
        check("t1_bank_empty", n_empty - e0, 1);
        check("t1_out_last", n_last - l0, 0);
        check("t1_ended", ended, 0);

        // Three banks against a half-rate reader.
        restart();
        rdy_mode = 1;
        b = n_smp; f0 = n_full; e0 = n_empty; s0 = n_stall;
        push_burst(96, 0, 1'b0);
        wait_smp(b + 384, 4000);
        check_stream("t2", b, 384, 0, 1'b0);
        check("t2_backpressure", (n_stall - s0) > 0, 1);
        check("t2_bank_full", n_full - f0, 3);
        check("t2_bank_empty", n_empty - e0, 3);
        rdy_mode = 0;

        // Partial bank flushed.
        restart();
        b = n_smp; f0 = n_full; l0 = n_last;
        push_burst(5, 0, 1'b0);
        pulse_end();
        wait_smp(b + 20, 1000);
        check_stream("t3", b, 20, 0, 1'b0);
        check("t3_last_count", n_last - l0, 1);
        check("t3_last_on_20th", last_q[b + 19], 1);
        check("t3_ended_delay", ended_rise_cyc - last_hs_cyc, 1);
        check("t3_ended", ended, 1);
        check("t3_bank_full", n_full - f0, 1);

        // Full bank, then flush with nothing in the second bank.
        restart();
        b = n_smp; f0 = n_full; e0 = n_empty; l0 = n_last;
        push_burst(32, 0, 1'b0);
        pulse_end();
        wait_smp(b + 128, 2000);
        check_stream("t4", b, 128, 0, 1'b0);
        check("t4_last_count", n_last - l0, 1);
        check("t4_last_on_128th", last_q[b + 127], 1);
        check("t4_bank_full", n_full - f0, 1);
        check("t4_bank_empty", n_empty - e0, 1);
        check("t4_ended", ended, 1);

        // Flush with no data written.
        restart();
        b = n_smp; f0 = n_full;
        pulse_end();
        @(posedge clk);
        #1;
        check("t5_ended_2cyc", ended, 1);
        check("t5_in_ready", bus.in_ready, 0);
        repeat (5) @(posedge clk);
        #1;
        check("t5_no_samples", n_smp - b, 0);
        check("t5_bank_full", n_full - f0, 0);

        // begin_pp dropped mid-drain, then a fresh burst.
        restart();
        b = n_smp;
        push_burst(32, 0, 1'b0);
        wait_smp(b + 20, 1000);
        @(posedge clk);
        #1;
        begin_pp = 1'b0;
        @(posedge clk);
        #1;
        check_idle_outputs("t6_begin_low");
        begin_pp = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        b = n_smp;
        push_burst(32, 1000, 1'b1);
        wait_smp(b + 128, 2000);
        check_stream("t6_restart", b, 128, 1000, 1'b1);

        // Asynchronous reset mid-drain, then a fresh burst.
        b = n_smp;
        push_burst(32, 0, 1'b0);
        wait_smp(b + 20, 1000);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("t6_async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        b = n_smp;
        push_burst(32, 2000, 1'b1);
        wait_smp(b + 128, 2000);
        check_stream("t6_after_rst", b, 128, 2000, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
